uart_cmd_ctrl: RTL

Packet controller between the UART RX/TX byte streams and the 32-bit arithmetic datapath.
- Parses command frames: opcode, reserved byte, 16-bit word count (LSB first), then N 32-bit operands (MSB byte first).
- Streams the operands to the datapath, collects the single 32-bit result and serialises it back to UART TX, MSB byte first.
- Sits between uart_rx/uart_tx and the datapath in the top level; it is the only sequencer of the datapath.

---
 rtl/config_pkg.sv | 29 ++
 rtl/uart_cmd_word_ser.sv | 51 +++++
 rtl/uart_cmd_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the UART command controller: opcodes, FSM state
// type and word geometry. Imported by uart_cmd_ctrl and uart_cmd_word_ser.
package config_pkg;

  // Opcodes the datapath understands; anything else is drained silently.
  localparam logic [7:0] OPC_ADD = 8'h02;
  localparam logic [7:0] OPC_MUL = 8'h03;

  // Bytes per 32-bit operand/result word on the UART side.
  localparam int WORD_BYTES = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RSV,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_SEND,
    ST_DRAIN
  } uart_cmd_state_e;

  // True for opcodes that are forwarded to the datapath.
  function automatic logic opc_supported(input logic [7:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_MUL);
  endfunction

endpackage

// File: rtl/uart_cmd_word_ser.sv
// 32-bit word to byte serialiser, MSB byte first, valid/ready on both sides.
// A word is accepted only while idle; the byte output is a registered shift
// register so the byte is stable for as long as o_byte_valid is held.
module uart_cmd_word_ser
  import config_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_word,
  input  logic        i_word_valid,
  output logic        o_word_ready,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_last_byte_done
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_valid;
  logic        w_byte_xfer;

  assign w_byte_xfer      = r_valid & i_byte_ready;
  assign o_word_ready     = ~r_valid;
  assign o_byte           = r_shift[31:24];
  assign o_byte_valid     = r_valid;
  assign o_last_byte_done = w_byte_xfer & (r_idx == LAST_IDX);

  // Load a word when idle, then shift one byte out per accepted transfer;
  // zeros shift in so the byte output returns to 0 after the last byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_word_valid && !r_valid) begin
      r_shift <= i_word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_byte_xfer) begin
      r_shift <= {r_shift[23:0], 8'h00};
      r_idx   <= r_idx + 2'd1;
      if (r_idx == LAST_IDX) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame sequencer between uart_rx/uart_tx and the 32-bit datapath.
// Frame: opcode, reserved byte, 16-bit word count (LSB first), then N
// operands MSB byte first. The single result is returned MSB byte first.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
  import config_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned TIMEOUT_US  = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  op_code_o,
  output logic [31:0] op_data_o,
  output logic        op_valid_o,
  output logic        op_last_o,
  input  logic        op_ready_i,
  input  logic [31:0] res_data_i,
  input  logic        res_valid_i,
  output logic        res_ready_o
  ,
  output logic        busy_o
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  uart_cmd_state_e r_state;
  uart_cmd_state_e w_state_next;

  logic [7:0]  r_opcode;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [17:0] r_drain;
  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;
  logic        r_rx_ready;
  logic        r_op_valid;
  logic        r_op_last;
  logic        r_res_ready;
  logic        r_busy;

  logic        w_rx_acc;
  logic        w_op_xfer;
  logic        w_res_xfer;
  logic [15:0] w_len_full;
  logic        w_supported;
  logic        w_zero_res;
  logic        w_ser_load;
  logic [31:0] w_ser_word;
  logic        w_ser_ready;
  logic        w_ser_done;
  logic        w_timeout;

  assign w_rx_acc    = rx_valid_i & r_rx_ready;
  assign w_op_xfer   = r_op_valid & op_ready_i;
  assign w_res_xfer  = r_res_ready & res_valid_i;
  assign w_len_full  = {rx_data_i, r_len[7:0]};
  assign w_supported = opc_supported(r_opcode);

  // Supported opcode with N=0 answers 0 straight away without the datapath.
  assign w_zero_res  = (r_state == ST_LEN_HI) & w_rx_acc & w_supported &
                       (w_len_full == 16'd0);
  assign w_ser_load  = w_res_xfer | w_zero_res;
  assign w_ser_word  = w_res_xfer ? res_data_i : 32'h0000_0000;

  assign rx_ready_o  = r_rx_ready;
  assign op_code_o   = r_opcode;
  assign op_data_o   = r_word;
  assign op_valid_o  = r_op_valid;
  assign op_last_o   = r_op_last;
  assign res_ready_o = r_res_ready;
  assign busy_o      = r_busy;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;

  logic [31:0] r_to_cnt;
  logic        w_timed;

  assign w_timed = (r_state == ST_RSV) || (r_state == ST_LEN_LO) ||
                   (r_state == ST_LEN_HI) || (r_state == ST_PAYLOAD) ||
                   (r_state == ST_DRAIN);

  // Idle-cycle counter for byte-waiting states; any accepted byte restarts it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (w_rx_acc || !w_timed) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  // A byte accepted in the same cycle wins over the timeout.
  assign w_timeout = w_timed && !w_rx_acc && (r_to_cnt >= TO_LIMIT - 1);
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state selection from the current state and handshakes.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_rx_acc) w_state_next = ST_RSV;
      ST_RSV:      if (w_rx_acc) w_state_next = ST_LEN_LO;
      ST_LEN_LO:   if (w_rx_acc) w_state_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (w_rx_acc) begin
          if (w_supported) begin
            w_state_next = (w_len_full == 16'd0) ? ST_SEND : ST_PAYLOAD;
          end else begin
            w_state_next = (w_len_full == 16'd0) ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_PAYLOAD:  if (w_rx_acc && (r_byte_idx == LAST_BYTE)) w_state_next = ST_ISSUE;
      ST_ISSUE:    if (w_op_xfer) w_state_next = r_op_last ? ST_WAIT_RES : ST_PAYLOAD;
      ST_WAIT_RES: if (w_res_xfer) w_state_next = ST_SEND;
      ST_SEND:     if (w_ser_done) w_state_next = ST_IDLE;
      ST_DRAIN:    if (w_rx_acc && (r_drain == 18'd1)) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end
  end

  // Frame FSM: state, registered handshake outputs and frame registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_opcode    <= '0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_drain     <= '0;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_rx_ready  <= 1'b0;
      r_op_valid  <= 1'b0;
      r_op_last   <= 1'b0;
      r_res_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rx_ready  <= (w_state_next == ST_IDLE) || (w_state_next == ST_RSV) ||
                     (w_state_next == ST_LEN_LO) || (w_state_next == ST_LEN_HI) ||
                     (w_state_next == ST_PAYLOAD) || (w_state_next == ST_DRAIN);
      r_busy      <= (w_state_next != ST_IDLE);
      r_op_valid  <= (w_state_next == ST_ISSUE);
      // The counter only moves on an operand transfer, which also leaves
      // ISSUE, so the current count is the index of the word being issued.
      r_op_last   <= (w_state_next == ST_ISSUE) && (r_word_cnt == r_len - 16'd1);
      r_res_ready <= (w_state_next == ST_WAIT_RES);

      if (w_rx_acc && !w_timeout) begin
        unique case (r_state)
          ST_IDLE:   r_opcode <= rx_data_i;
          ST_LEN_LO: r_len[7:0] <= rx_data_i;
          ST_LEN_HI: begin
            r_len[15:8] <= rx_data_i;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_drain     <= {w_len_full, 2'b00};
          end
          ST_PAYLOAD: begin
            r_word     <= {r_word[23:0], rx_data_i};
            r_byte_idx <= r_byte_idx + 2'd1;
          end
          ST_DRAIN:  r_drain <= r_drain - 18'd1;
          default: ;
        endcase
      end

      if (w_op_xfer) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  uart_cmd_word_ser u_ser (
    .i_clk            (clk_i),
    .i_rst_n          (rst_ni),
    .i_word           (w_ser_word),
    .i_word_valid     (w_ser_load),
    .o_word_ready     (w_ser_ready),
    .o_byte           (tx_data_o),
    .o_byte_valid     (tx_valid_o),
    .i_byte_ready     (tx_ready_i),
    .o_last_byte_done (w_ser_done)
  );

  // Loads are only issued while the serialiser is idle (outside SEND),
  // so its word-ready is informational here.
  logic w_ser_ready_unused;
  assign w_ser_ready_unused = w_ser_ready;

endmodule
